regfile_wb_arbiter: RTL and testbench

Write-back arbiter for the processor's register file. It shares the file's single write port among `num_req` write-back sources, such as ALU, load unit and CSR path. Per-source valid/ready handshakes are resolved by round-robin arbitration. The winning write is registered and presented to the register file one cycle later. A saturating counter reports how often sources collided.

---
 rtl/wb_arb_pkg.sv | 23 ++
 rtl/rr_pick.sv | 34 +++
 rtl/regfile_wb_arbiter.sv | 85 ++++++++
 tb/tb_regfile_wb_arbiter.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arb_pkg.sv
// Shared defaults, width helpers and the write-back request record for regfile_wb_arbiter.
package wb_arb_pkg;

    localparam int def_num_req  = 4;
    localparam int def_reg_size = 32;
    localparam int def_mem_size = 32;
    localparam int def_cnt_size = 16;

    // Index width for a table of 'depth' entries; never below one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [addr_width(def_mem_size)-1:0] addr;
        logic [def_reg_size-1:0]             data;
    } wb_req_t;

endpackage

// File: rtl/rr_pick.sv
// One-hot selector: grants the first set bit of req, scanning upward from start and wrapping.
module rr_pick
    import wb_arb_pkg::*;
#(
    parameter int  n  = def_num_req,
    localparam int pw = ptr_width(n)
) (
    input  logic [n-1:0]  req,
    input  logic [pw-1:0] start,
    output logic [n-1:0]  grant,
    output logic [pw-1:0] grant_idx,
    output logic          any
);

    int slot;

    // Scanning from the far end lets the nearest-to-start request overwrite all others.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        slot      = 0;
        for (int k = n - 1; k >= 0; k--) begin
            slot = (int'(start) + k) % n;
            if (req[slot]) begin
                grant       = '0;
                grant[slot] = 1'b1;
                grant_idx   = pw'(slot);
                any         = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register file's write port among num_req write-back sources with a registered output.
// WB_ARB_RR_EN selects round-robin priority; when undefined the lowest index always wins.
module regfile_wb_arbiter
    import wb_arb_pkg::*;
#(
    parameter int  reg_size = def_reg_size,
    parameter int  mem_size = def_mem_size,
    parameter int  num_req  = def_num_req,
    parameter int  cnt_size = def_cnt_size,
    localparam int aw       = addr_width(mem_size),
    localparam int pw       = ptr_width(num_req)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [num_req-1:0]                req_valid,
    input  logic [num_req-1:0][aw-1:0]        req_addr,
    input  logic [num_req-1:0][reg_size-1:0]  req_data,
    output logic [num_req-1:0]                req_ready,
    input  logic                              hold,
    output logic                              wr_en,
    output logic [aw-1:0]                     wr_addr,
    output logic [reg_size-1:0]               wr_data,
    output logic [cnt_size-1:0]               collide_cnt
);

    // Handshake: req_ready is one-hot and combinational; source i transfers on a rising edge
    // where req_valid[i] && req_ready[i]. Sources hold valid/addr/data stable until that edge.

    logic [pw-1:0]      ptr;
    logic [num_req-1:0] pick;
    logic [pw-1:0]      pick_idx;
    logic               pick_any;
    logic               grant_en;
    logic               accept;
    logic               collide;

    rr_pick #(.n(num_req)) u_pick (
        .req       (req_valid),
        .start     (ptr),
        .grant     (pick),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    assign grant_en  = !rst && !hold;
    assign req_ready = grant_en ? pick : '0;
    assign accept    = grant_en && pick_any;
    assign collide   = !hold && ($countones(req_valid) >= 2);

`ifdef WB_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (accept) begin
            ptr <= (int'(pick_idx) == num_req - 1) ? '0 : pick_idx + pw'(1);
        end
    end
`else
    assign ptr = '0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            collide_cnt <= '0;
        end else if (collide && (collide_cnt != '1)) begin
            collide_cnt <= collide_cnt + cnt_size'(1);
        end
    end

    // Address and data hold their last value on idle cycles; only the strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                wr_addr <= req_addr[pick_idx];
                wr_data <= req_data[pick_idx];
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_regfile_wb_arbiter;
    import wb_arb_pkg::*;

    localparam int NR = 4;
    localparam int RS = 32;
    localparam int MS = 32;
    localparam int CS = 4;
    localparam int AW = addr_width(MS);
    localparam int CNT_MAX = (1 << CS) - 1;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst = 1'b1;
    logic                     hold = 1'b0;
    logic [NR-1:0]            req_valid = '0;
    logic [NR-1:0][AW-1:0]    req_addr = '0;
    logic [NR-1:0][RS-1:0]    req_data = '0;
    logic [NR-1:0]            req_ready;
    logic                     wr_en;
    logic [AW-1:0]            wr_addr;
    logic [RS-1:0]            wr_data;
    logic [CS-1:0]            collide_cnt;

    regfile_wb_arbiter #(
        .reg_size (RS),
        .mem_size (MS),
        .num_req  (NR),
        .cnt_size (CS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .hold        (hold),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .collide_cnt (collide_cnt)
    );

    // register file driven by the arbiter's write port
    logic [RS-1:0] rf [MS];
    always @(posedge clk) if (wr_en) rf[wr_addr] <= wr_data;

    // reference model and scoreboard
    int            n_cmp = 0;
    int            n_err = 0;
    int            m_ptr = 0;
    logic          m_en = 1'b0;
    logic [AW-1:0] m_addr = '0;
    logic [RS-1:0] m_data = '0;
    int            m_cnt = 0;
    logic [AW+RS-1:0] exp_q[$];
    int            grants[$];

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock cycle: check ready against the model, advance the model, check the registered outputs.
    task automatic step(output int g);
        logic [NR-1:0] exp_rdy;
        wb_req_t       w;
        #1;
        g = -1;
        exp_rdy = '0;
        if (!rst && !hold)
            for (int k = NR - 1; k >= 0; k--)
                if (req_valid[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));
        if (rst) begin
            m_en = 1'b0; m_addr = '0; m_data = '0; m_ptr = 0; m_cnt = 0;
            exp_q.delete();
        end else begin
            if (!hold && $countones(req_valid) >= 2 && m_cnt < CNT_MAX) m_cnt++;
            m_en = (g >= 0);
            if (g >= 0) begin
                m_addr = req_addr[g];
                m_data = req_data[g];
                w.addr = req_addr[g];
                w.data = req_data[g];
                exp_q.push_back(w);
                grants.push_back(g);
`ifdef WB_ARB_RR_EN
                m_ptr = (g + 1) % NR;
`endif
            end
        end
        @(posedge clk);
        #1;
        check("wr_en", 64'(wr_en), 64'(m_en));
        check("wr_addr", 64'(wr_addr), 64'(m_addr));
        check("wr_data", 64'(wr_data), 64'(m_data));
        check("collide_cnt", 64'(collide_cnt), 64'(m_cnt));
        if (wr_en) begin
            if (exp_q.size() == 0) check("sb_pending", 64'(exp_q.size()), 64'd1);
            else check("sb_write", 64'({wr_addr, wr_data}), 64'(exp_q.pop_front()));
        end
    endtask

    // driver tasks
    task automatic set_src(input int i, input logic v, input logic [AW-1:0] a, input logic [RS-1:0] d);
        req_valid[i] = v;
        req_addr[i]  = a;
        req_data[i]  = d;
    endtask

    task automatic rand_src(input int i, input logic v);
        set_src(i, v, AW'($urandom_range(0, MS - 1)), $urandom);
    endtask

    task automatic do_reset();
        int g;
        rst = 1'b1;
        hold = 1'b0;
        req_valid = '0;
        step(g);
        step(g);
        rst = 1'b0;
    endtask

    initial begin
        int g;
        int exp_g;
        logic [CS-1:0] cnt_before;

        // reset state
        do_reset();
        check("reset_wr_en", 64'(wr_en), 64'd0);
        check("reset_cnt", 64'(collide_cnt), 64'd0);

        // single request
        set_src(0, 1'b1, AW'(5), 32'hDEADBEEF);
        #1;
        check("single_ready", 64'(req_ready), 64'b0001);
        step(g);
        check("single_addr", 64'(wr_addr), 64'd5);
        check("single_data", 64'(wr_data), 64'hDEADBEEF);
        req_valid = '0;
        step(g);

        // all sources valid for 8 cycles from ptr=0
        do_reset();
        for (int i = 0; i < NR; i++) rand_src(i, 1'b1);
        grants.delete();
        for (int c = 0; c < 8; c++) begin
            step(g);
            if (g >= 0) rand_src(g, 1'b1);
        end
        check("order_len", 64'(grants.size()), 64'd8);
        for (int c = 0; c < 8 && c < grants.size(); c++) begin
`ifdef WB_ARB_RR_EN
            exp_g = c % NR;
`else
            exp_g = 0;
`endif
            check("order", 64'(grants[c]), 64'(exp_g));
        end
        check("cnt_after_8", 64'(collide_cnt), 64'd8);

        // same-address requests from sources 1 and 3, ptr moved to 2 first
        do_reset();
        req_valid = '0;
        rand_src(1, 1'b1);
        step(g);
        req_valid = '0;
        set_src(1, 1'b1, AW'(7), 32'h11);
        set_src(3, 1'b1, AW'(7), 32'h33);
        grants.delete();
        for (int c = 0; c < 2; c++) begin
            step(g);
            if (g >= 0) req_valid[g] = 1'b0;
        end
        step(g);
        step(g);
`ifdef WB_ARB_RR_EN
        check("same_addr_first", 64'(grants[0]), 64'd3);
        check("same_addr_rf7", 64'(rf[7]), 64'h11);
`else
        check("same_addr_first", 64'(grants[0]), 64'd1);
        check("same_addr_rf7", 64'(rf[7]), 64'h33);
`endif

        // hold for 3 cycles with sources 1 and 2 valid
        do_reset();
        rand_src(0, 1'b1);
        step(g);
        req_valid = '0;
        rand_src(1, 1'b1);
        rand_src(2, 1'b1);
        hold = 1'b1;
        cnt_before = collide_cnt;
        for (int c = 0; c < 3; c++) begin
            step(g);
            check("hold_wr_en", 64'(wr_en), 64'd0);
        end
        check("hold_cnt", 64'(collide_cnt), 64'(cnt_before));
        hold = 1'b0;
        #1;
        check("hold_resume", 64'(req_ready), 64'b0010);
        step(g);
        req_valid = '0;
        step(g);

        // reset in the same cycle as an acceptance
        do_reset();
        for (int i = 0; i < NR; i++) rand_src(i, 1'b1);
        for (int c = 0; c < 2; c++) begin
            step(g);
            if (g >= 0) rand_src(g, 1'b1);
        end
        rst = 1'b1;
        step(g);
        check("rst_wr_en", 64'(wr_en), 64'd0);
        check("rst_cnt", 64'(collide_cnt), 64'd0);
        step(g);
        rst = 1'b0;
        #1;
        check("rst_ptr0", 64'(req_ready), 64'b0001);
        step(g);

        // counter saturation
        do_reset();
        for (int i = 0; i < NR; i++) rand_src(i, 1'b1);
        for (int c = 0; c < 20; c++) begin
            step(g);
            if (g >= 0) rand_src(g, 1'b1);
        end
        check("cnt_saturate", 64'(collide_cnt), 64'(CNT_MAX));

        // randomized traffic
        do_reset();
        for (int c = 0; c < 400; c++) begin
            hold = ($urandom_range(0, 7) == 0);
            rst  = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < NR; i++)
                if (!req_valid[i] && $urandom_range(0, 2) == 0) rand_src(i, 1'b1);
            step(g);
            if (g >= 0) rand_src(g, 1'($urandom_range(0, 1)));
        end
        rst = 1'b0;
        hold = 1'b0;
        req_valid = '0;
        step(g);
        step(g);
        check("sb_drained", 64'(exp_q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
